mem_bus_ctrl: RTL

Parametrised, handshaked memory-map controller between the core's data port and its memory-mapped slaves (data RAM, stack RAM, GPIO, UART TX/RX). It decodes the request address against N_SLV base/mask regions, drives a one-hot select with the region offset to the chosen slave, and waits for that slave's acknowledge. Unmapped addresses and unresponsive slaves return a bus error. It replaces the fixed-address combinational decoder for multi-cycle slaves.

---
 rtl/mem_map_pkg.sv | 56 +++++
 rtl/mem_region_decoder.sv | 31 +++
 rtl/mem_bus_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg
// Shared definitions for the memory-map controller:
//   - state_t        : controller FSM states (IDLE, ACCESS, RESP)
//   - DEF_N_SLV      : number of slave regions in the default map
//   - DEF_SLV_BASE   : packed default region bases, slave i at [i*32 +: 32]
//   - DEF_SLV_MASK   : packed default region masks (1 = compared, 0 = offset)
//   - SLV_*          : slave index of each default region
// The ROM sits on the instruction side and is not a data-port slave; its base
// is kept here so the whole system map lives in one place.
package mem_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int DEF_N_SLV = 6;

    localparam int SLV_DRAM     = 0;
    localparam int SLV_STACK    = 1;
    localparam int SLV_GPIO_OUT = 2;
    localparam int SLV_GPIO_IN  = 3;
    localparam int SLV_UART_RX  = 4;
    localparam int SLV_UART_TX  = 5;

    localparam logic [31:0] ROM_BASE      = 32'h0040_0000;
    localparam logic [31:0] DRAM_BASE     = 32'h1001_0000;
    localparam logic [31:0] GPIO_OUT_BASE = 32'h1001_0024;
    localparam logic [31:0] GPIO_IN_BASE  = 32'h1001_0028;
    localparam logic [31:0] UART_RX_BASE  = 32'h1001_002C;
    localparam logic [31:0] UART_TX_BASE  = 32'h1001_0030;
    localparam logic [31:0] STACK_BASE    = 32'h7FFF_0000;

    // Data RAM is kept to the 32 bytes below the GPIO block so it does not
    // shadow the peripherals. UART TX decodes a 64-byte window so its slave
    // sees the low address bits (0x30 for its own register); the lower-index
    // regions win the overlapping addresses.
    localparam logic [31:0] DRAM_MASK     = 32'hFFFF_FFE0;
    localparam logic [31:0] STACK_MASK    = 32'hFFFF_0000;
    localparam logic [31:0] GPIO_OUT_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] GPIO_IN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] UART_RX_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] UART_TX_MASK  = 32'hFFFF_FFC0;

    localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_BASE = {
        UART_TX_BASE, UART_RX_BASE, GPIO_IN_BASE,
        GPIO_OUT_BASE, STACK_BASE, DRAM_BASE
    };

    localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_MASK = {
        UART_TX_MASK, UART_RX_MASK, GPIO_IN_MASK,
        GPIO_OUT_MASK, STACK_MASK, DRAM_MASK
    };

endpackage

// File: rtl/mem_region_decoder.sv
// mem_region_decoder
// Combinational base/mask address decoder with fixed priority.
//   addr    in  ADDR_W  byte address to decode
//   hit_vec out N_SLV   one-hot hit, lowest matching region index wins
//   hit     out 1       any region matched
module mem_region_decoder #(
    parameter int                        ADDR_W   = 32,
    parameter int                        N_SLV    = 6,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_SLV-1:0]  hit_vec,
    output logic              hit
);

    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        // Ascending scan; once a region hits, higher indices are ignored.
        for (int i = 0; i < N_SLV; i++) begin
            if (!hit &&
                ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                 (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Handshaked memory-map controller between the core data port and the
// memory-mapped slaves. One request in flight: IDLE accepts, ACCESS waits for
// the selected slave's ack (or a timeout), RESP emits a one-cycle response.
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata    request payload
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response, no backpressure
//   slv_sel, slv_we, slv_addr,     slave-side request, held through ACCESS
//   slv_wdata
//   slv_rdata, slv_ack             per-slave read data and completion
//   err_cnt                        saturating count of error responses
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter int                      N_SLV    = 6,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int                      TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [N_SLV-1:0]        slv_sel,
    output logic                    slv_we,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_ack,
    output logic [7:0]              err_cnt
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  wait_q;
    logic [N_SLV-1:0]  hit_vec;
    logic              hit;
    logic [ADDR_W-1:0] sel_mask;
    logic [DATA_W-1:0] sel_rdata;
    logic              ack_sel;
    logic              timeout_hit;

    mem_region_decoder #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr    (req_addr),
        .hit_vec (hit_vec),
        .hit     (hit)
    );

    // Mask of the region being decoded; hit_vec is one-hot so OR-ing is a mux.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (hit_vec[i]) sel_mask = sel_mask | SLV_MASK[i*ADDR_W +: ADDR_W];
        end
    end

    // Read data of the currently selected slave (one-hot OR mux).
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (slv_sel[i]) sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
        end
    end

    // Only the selected slave's ack counts; slv_sel is zero outside ACCESS.
    assign ack_sel     = |(slv_ack & slv_sel);
    // wait_q counts completed ACCESS cycles, so TIMEOUT-1 marks the last one.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));
    assign req_ready   = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                // Stage: request acceptance and decode capture
                ST_IDLE: begin
                    if (req_valid) begin
                        if (hit) begin
                            state_q   <= ST_ACCESS;
                            slv_sel   <= hit_vec;
                            slv_we    <= req_we;
                            slv_addr  <= req_addr & ~sel_mask;
                            slv_wdata <= req_wdata;
                        end else begin
                            state_q   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                // Stage: slave access, waiting for ack or timeout
                ST_ACCESS: begin
                    if (ack_sel) begin
                        state_q   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= slv_we ? '0 : sel_rdata;
                        slv_sel   <= '0;
                        slv_we    <= 1'b0;
                        wait_q    <= '0;
                    end else if (timeout_hit) begin
                        state_q   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        slv_sel   <= '0;
                        slv_we    <= 1'b0;
                        wait_q    <= '0;
                    end else begin
                        wait_q    <= wait_q + 1'b1;
                    end
                end
                // Stage: response strobe
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (rsp_err) err_cnt <= sat_inc8(err_cnt);
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
